singcyc_data_mem: RTL

SINGCYC_DATA_MEM -- requirements
Module: singcyc_data_mem

---
 rtl/singcyc_data_mem_pkg.sv | 49 ++++
 rtl/singcyc_data_mem_if.sv | 26 ++
 rtl/singcyc_dmem_timer.sv | 66 ++++++
 rtl/singcyc_data_mem.sv | 117 +++++++++++
 4 files changed

// File: rtl/singcyc_data_mem_pkg.sv
// Shared constants for the single-cycle data memory: peripheral offsets, TCON bit
// positions, the default peripheral window base and the address decoder.
package singcyc_data_mem_pkg;

    localparam logic [31:0] DEFAULT_PERIPH_BASE = 32'h4000_0000;

    localparam logic [31:0] OFF_TH      = 32'h00;
    localparam logic [31:0] OFF_TL      = 32'h04;
    localparam logic [31:0] OFF_TCON    = 32'h08;
    localparam logic [31:0] OFF_LED     = 32'h0C;
    localparam logic [31:0] OFF_SWITCH  = 32'h10;
    localparam logic [31:0] OFF_SYSTICK = 32'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_SWITCH,
        SEL_SYSTICK
    } dmem_sel_e;

    // RAM takes precedence if a misconfigured window ever overlaps it.
    function automatic dmem_sel_e dmem_decode(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input logic [31:0] ram_bytes);
        logic [31:0] off;
        off = (addr - base) & ~32'd3;
        if (addr < ram_bytes) begin
            return SEL_RAM;
        end
        case (off)
            OFF_TH:      return SEL_TH;
            OFF_TL:      return SEL_TL;
            OFF_TCON:    return SEL_TCON;
            OFF_LED:     return SEL_LED;
            OFF_SWITCH:  return SEL_SWITCH;
            OFF_SYSTICK: return SEL_SYSTICK;
            default:     return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/singcyc_data_mem_if.sv
// Core-side data bus of the single-cycle data memory; the core is the master.
interface singcyc_data_mem_if;

    logic [31:0] iAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iWrData;
    logic [31:0] oRdData;

    modport master (
        output iAddr,
        output iMemRead,
        output iMemWrite,
        output iWrData,
        input  oRdData
    );

    modport slave (
        input  iAddr,
        input  iMemRead,
        input  iMemWrite,
        input  iWrData,
        output oRdData
    );

endinterface

// File: rtl/singcyc_dmem_timer.sv
// Reloading 32-bit timer (TH/TL/TCON) with a level interrupt; only built when
// DMEM_TIMER_EN is defined.
module singcyc_dmem_timer
    import singcyc_data_mem_pkg::*;
(
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wr_data,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;

    // Bus writes are applied last so they override the timer's own update.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        if (tcon_q[TCON_EN]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[TCON_IE]) begin
                    tcon_d[TCON_ST] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        if (wr_th) begin
            th_d = wr_data;
        end
        if (wr_tl) begin
            tl_d   = wr_data;
            tcon_d = tcon_q;
        end
        if (wr_tcon) begin
            tcon_d = wr_data[2:0];
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    assign th   = th_q;
    assign tl   = tl_q;
    assign tcon = tcon_q;
    assign irq  = tcon_q[TCON_IE] & tcon_q[TCON_ST];

endmodule

// File: rtl/singcyc_data_mem.sv
// Single-cycle data memory: word RAM plus a peripheral window (LED, switches,
// SYSTICK and, with DMEM_TIMER_EN defined, the TH/TL/TCON timer).
module singcyc_data_mem
    import singcyc_data_mem_pkg::*;
#(
    parameter int          RAM_WORDS   = 256,
    parameter logic [31:0] PERIPH_BASE = DEFAULT_PERIPH_BASE
) (
    input  logic                iClk,
    input  logic                iRst_n,
    singcyc_data_mem_if.slave   bus,
    input  logic [7:0]          iSwitch,
    output logic [7:0]          oLed,
    output logic                oIrq
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    dmem_sel_e   sel;
    logic [AW-1:0] ram_idx;
    logic        ram_we;
    logic        wr_led;
    logic [31:0] rd_data;

    logic [31:0] ram_q [RAM_WORDS];

    logic [7:0]  led_q, led_d;
    logic [7:0]  sw_meta_q, sw_meta_d;
    logic [7:0]  sw_sync_q, sw_sync_d;
    logic [31:0] systick_q, systick_d;

    always_comb begin
        sel     = dmem_decode(bus.iAddr, PERIPH_BASE, RAM_BYTES);
        ram_idx = bus.iAddr[AW+1:2];
        ram_we  = bus.iMemWrite && (sel == SEL_RAM);
        wr_led  = bus.iMemWrite && (sel == SEL_LED);
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] timer_th;
    logic [31:0] timer_tl;
    logic [2:0]  timer_tcon;
    logic        timer_irq;

    singcyc_dmem_timer u_timer (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .wr_th   (bus.iMemWrite && (sel == SEL_TH)),
        .wr_tl   (bus.iMemWrite && (sel == SEL_TL)),
        .wr_tcon (bus.iMemWrite && (sel == SEL_TCON)),
        .wr_data (bus.iWrData),
        .th      (timer_th),
        .tl      (timer_tl),
        .tcon    (timer_tcon),
        .irq     (timer_irq)
    );

    assign oIrq = timer_irq;
`else
    assign oIrq = 1'b0;
`endif

    // RAM has no reset: its contents must survive a reset of the peripherals.
    always_ff @(posedge iClk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= bus.iWrData;
        end
    end

    always_comb begin
        led_d     = led_q;
        sw_meta_d = iSwitch;
        sw_sync_d = sw_meta_q;
        systick_d = systick_q + 32'd1;
        if (wr_led) begin
            led_d = bus.iWrData[7:0];
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            systick_q <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            systick_q <= systick_d;
        end
    end

    // Reads see pre-edge state, so a same-cycle write returns the old value.
    always_comb begin
        rd_data = '0;
        if (bus.iMemRead) begin
            case (sel)
                SEL_RAM:     rd_data = ram_q[ram_idx];
`ifdef DMEM_TIMER_EN
                SEL_TH:      rd_data = timer_th;
                SEL_TL:      rd_data = timer_tl;
                SEL_TCON:    rd_data = {29'd0, timer_tcon};
`endif
                SEL_LED:     rd_data = {24'd0, led_q};
                SEL_SWITCH:  rd_data = {24'd0, sw_sync_q};
                SEL_SYSTICK: rd_data = systick_q;
                default:     rd_data = '0;
            endcase
        end
    end

    assign bus.oRdData = rd_data;
    assign oLed        = led_q;

endmodule
